pdm_cic_decimator: RTL and testbench

//  Generates the PDM microphone clock and samples the 1-bit PDM stream on the selected edge.

---
 rtl/pdm_pkg.sv | 20 ++
 rtl/pdm_clk_gen.sv | 33 +++
 rtl/pdm_cic_decimator.sv | 138 +++++++++++++
 tb/tb_pdm_cic_decimator.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// rtl/pdm_pkg.sv - shared constants and helpers for the PDM CIC decimator
package pdm_pkg;

  localparam int CIC_ORDER = 3;
  localparam int PCM_W     = 16;

  function automatic int cic_w(input int dec_log2);
    return CIC_ORDER * dec_log2 + 2;
  endfunction

  function automatic logic signed [PCM_W-1:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)
      return 16'sh7fff;
    else if (v < -32'sd32768)
      return 16'sh8000;
    else
      return v[PCM_W-1:0];
  endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// rtl/pdm_clk_gen.sv - PDM mclk divider and sample strobe on the lr_sel-selected edge
module pdm_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic lr_sel,
  output logic mclk,
  output logic strobe
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      cnt  <= '0;
      mclk <= 1'b0;
    end else begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      if (cnt == HALF_M1 || cnt == LAST)
        mclk <= ~mclk;
    end
  end

  // mclk rises when leaving HALF_M1 and falls when leaving LAST
  assign strobe = enable && (cnt == (lr_sel ? LAST : HALF_M1));

endmodule

// File: rtl/pdm_cic_decimator.sv
// rtl/pdm_cic_decimator.sv - PDM capture, 3rd-order CIC decimator and PCM holding register
// Optional one-pole DC blocker after scaling: define PDM_DCBLOCK_EN.
module pdm_cic_decimator
  import pdm_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int DEC_LOG2 = 6,
  parameter int DC_SHIFT = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    lr_sel,
  input  logic                    pdm_data,
  output logic                    mclk,
  output logic signed [PCM_W-1:0] pcm_data,
  output logic                    pcm_valid,
  input  logic                    pcm_ready,
  output logic                    overrun
);

  localparam int W   = cic_w(DEC_LOG2);
  localparam int SH  = CIC_ORDER * DEC_LOG2 - (PCM_W - 1);
  localparam int SHR = (SH > 0) ? SH : 0;
  localparam int SHL = (SH < 0) ? -SH : 0;

  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0 || DEC_LOG2 < 4 || DEC_LOG2 > 7 ||
      DC_SHIFT < 1 || DC_SHIFT > 16) begin : g_param_check
    $error("pdm_cic_decimator: unsupported parameter set");
  end

  logic strobe;
  logic clear;

  pdm_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .lr_sel (lr_sel),
    .mclk   (mclk),
    .strobe (strobe)
  );

  logic signed [W-1:0] x, i1, i2, i3, z1, z2, z3, c1, c2, c3;
  logic [DEC_LOG2-1:0] dcnt;
  logic                v1, v2;

  assign clear = reset || !enable;
  assign x     = {{(W-1){~pdm_data}}, 1'b1};

  always_ff @(posedge clk) begin
    if (clear) begin
      i1 <= '0; i2 <= '0; i3 <= '0;
      z1 <= '0; z2 <= '0; z3 <= '0;
      c1 <= '0; c2 <= '0;
      dcnt <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= 1'b0;
      v2 <= v1;
      if (strobe) begin
        i1   <= i1 + x;
        i2   <= i2 + i1;
        i3   <= i3 + i2;
        dcnt <= dcnt + 1'b1;
        if (&dcnt) begin
          c1 <= i3 - z1;
          z1 <= i3;
          v1 <= 1'b1;
        end
      end
      if (v1) begin
        c2 <= c1 - z2;
        z2 <= c1;
      end
      if (v2)
        z3 <= c2;
    end
  end

  // Third comb stage is combinational; it feeds the holding register directly
  assign c3 = c2 - z3;

  logic signed [31:0]      c3_ext, scaled;
  logic signed [PCM_W-1:0] pcm_next;
  logic                    load;

  assign c3_ext = {{(32-W){c3[W-1]}}, c3};
  assign scaled = (c3_ext <<< SHL) >>> SHR;

`ifdef PDM_DCBLOCK_EN
  logic signed [PCM_W-1:0] s16;
  logic signed [17:0]      xs18, x1, y1, y_next;
  logic                    v3;

  assign s16    = sat16(scaled);
  assign xs18   = {{2{s16[PCM_W-1]}}, s16};
  assign y_next = xs18 - x1 + y1 - (y1 >>> DC_SHIFT);

  always_ff @(posedge clk) begin
    if (clear) begin
      x1 <= '0;
      y1 <= '0;
      v3 <= 1'b0;
    end else begin
      v3 <= v2;
      if (v2) begin
        x1 <= xs18;
        y1 <= y_next;
      end
    end
  end

  assign load     = v3;
  assign pcm_next = sat16({{14{y1[17]}}, y1});
`else
  assign load     = v2;
  assign pcm_next = sat16(scaled);
`endif

  // Holding register survives enable=0 so a pending sample stays readable
  always_ff @(posedge clk) begin
    if (reset) begin
      pcm_data  <= '0;
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (load) begin
      pcm_data  <= pcm_next;
      pcm_valid <= 1'b1;
      if (pcm_valid && !pcm_ready)
        overrun <= 1'b1;
    end else if (pcm_valid && pcm_ready) begin
      pcm_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// tb/tb_pdm_cic_decimator.sv - self-checking bench for pdm_cic_decimator (default build)
module tb_pdm_cic_decimator;

  localparam int CLK_DIV  = 4;
  localparam int DEC_LOG2 = 6;
  localparam int R        = 1 << DEC_LOG2;
  localparam int W        = 3 * DEC_LOG2 + 2;
  localparam int PERIOD   = R * CLK_DIV;

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b0, lr_sel = 1'b0, pdm_data = 1'b0, pcm_ready = 1'b1;
  logic mclk, pcm_valid, overrun;
  logic signed [15:0] pcm_data;

  int nchk = 0, nerr = 0;

  // Reference model state: enabled edge count, sampled bits, i3 snapshots, scheduled loads
  int k = 0;
  longint xs[$];
  longint lh[$];
  int pend_e[$];
  int pend_v[$];
  bit hv = 1'b0, hov = 1'b0, mdl_load = 1'b0;
  logic signed [15:0] hd = '0;

  pdm_cic_decimator #(.CLK_DIV(CLK_DIV), .DEC_LOG2(DEC_LOG2), .DC_SHIFT(10)) dut (
    .clk(clk), .reset(reset), .enable(enable), .lr_sel(lr_sel), .pdm_data(pdm_data),
    .mclk(mclk), .pcm_data(pcm_data), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // i3 after n updates = sum x_j * C(n-1-j, 2); output = third difference of snapshots
  function automatic int cic_model();
    longint n, l, d, s;
    int m;
    logic signed [W-1:0] t;
    n = xs.size() - 1;
    l = 0;
    for (int j = 0; j < n; j++) l += xs[j] * (((n - 1 - j) * (n - 2 - j)) / 2);
    lh.push_back(l);
    m = lh.size();
    d = lh[m-1];
    if (m >= 2) d -= 3 * lh[m-2];
    if (m >= 3) d += 3 * lh[m-3];
    if (m >= 4) d -= lh[m-4];
    t = d[W-1:0];
    s = t;
    s = s >>> (3 * DEC_LOG2 - 15);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  task automatic tick(input logic d, input logic rdy);
    int v;
    v = 0;
    pdm_data  = d;
    pcm_ready = rdy;
    @(posedge clk);
    mdl_load = 1'b0;
    if (reset) begin
      k = 0; xs.delete(); lh.delete(); pend_e.delete(); pend_v.delete();
      hv = 1'b0; hov = 1'b0; hd = '0;
    end else begin
      if (!enable) begin
        k = 0; xs.delete(); lh.delete(); pend_e.delete(); pend_v.delete();
      end else begin
        k++;
        if (((k - 1) % CLK_DIV) == (lr_sel ? CLK_DIV - 1 : CLK_DIV / 2 - 1)) begin
          xs.push_back(d ? 1 : -1);
          if ((xs.size() % R) == 0) begin
            pend_e.push_back(k + 2);
            pend_v.push_back(cic_model());
          end
        end
        if (pend_e.size() > 0 && pend_e[0] == k) begin
          v = pend_v.pop_front();
          void'(pend_e.pop_front());
          mdl_load = 1'b1;
        end
      end
      if (mdl_load) begin
        if (hv && !rdy) hov = 1'b1;
        hv = 1'b1;
        hd = 16'(v);
      end else if (hv && rdy) begin
        hv = 1'b0;
      end
    end
    #1;
  endtask

  task automatic restart();
    enable = 1'b0;
    tick(1'b0, pcm_ready);
    enable = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0;
    repeat (3) tick(1'b1, 1'b1);
    nchk++; if (mclk !== 1'b0) begin nerr++; $display("FAIL reset_mclk: got %0b want 0", mclk); end
    nchk++; if (pcm_data !== 16'sd0) begin nerr++; $display("FAIL reset_data: got %0d want 0", pcm_data); end
    nchk++; if (pcm_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %0b want 0", pcm_valid); end
    nchk++; if (overrun !== 1'b0) begin nerr++; $display("FAIL reset_overrun: got %0b want 0", overrun); end
    reset = 1'b0;
  endtask

  task automatic test_const_one();
    int smp[$];
    int e, last_e;
    lr_sel = 1'b0;
    restart();
    e = 0; last_e = 0;
    for (int c = 0; c < 6 * PERIOD + 8; c++) begin
      tick(1'b1, 1'b1);
      e++;
      nchk++;
      if (pcm_valid !== hv || pcm_data !== hd || overrun !== hov) begin
        nerr++;
        $display("FAIL const_one edge %0d: got v=%0b d=%0d o=%0b, want v=%0b d=%0d o=%0b", k, pcm_valid, pcm_data, overrun, hv, hd, hov);
      end
      if (c < 64) begin
        nchk++;
        if (mclk !== ((k % CLK_DIV) >= CLK_DIV / 2)) begin
          nerr++; $display("FAIL mclk_wave edge %0d: got %0b want %0b", k, mclk, (k % CLK_DIV) >= CLK_DIV / 2);
        end
      end
      if (pcm_valid) begin
        if (smp.size() > 0) begin
          nchk++;
          if (e - last_e !== PERIOD) begin nerr++; $display("FAIL interval: got %0d want %0d", e - last_e, PERIOD); end
        end
        smp.push_back(pcm_data);
        last_e = e;
      end
    end
    nchk++; if (smp.size() !== 6) begin nerr++; $display("FAIL one_count: got %0d want 6", smp.size()); end
    for (int i = 2; i < smp.size(); i++) begin
      nchk++; if (smp[i] !== 32767) begin nerr++; $display("FAIL one_settled[%0d]: got %0d want 32767", i, smp[i]); end
    end
  endtask

  task automatic test_const_zero();
    int smp[$];
    restart();
    for (int c = 0; c < 5 * PERIOD + 8; c++) begin
      tick(1'b0, 1'b1);
      nchk++;
      if (pcm_valid !== hv || pcm_data !== hd || overrun !== hov) begin
        nerr++;
        $display("FAIL const_zero edge %0d: got v=%0b d=%0d o=%0b, want v=%0b d=%0d o=%0b", k, pcm_valid, pcm_data, overrun, hv, hd, hov);
      end
      if (pcm_valid) smp.push_back(pcm_data);
    end
    for (int i = 2; i < smp.size(); i++) begin
      nchk++; if (smp[i] !== -32768) begin nerr++; $display("FAIL zero_settled[%0d]: got %0d want -32768", i, smp[i]); end
    end
  endtask

  task automatic test_alternating();
    int smp[$];
    restart();
    for (int c = 0; c < 5 * PERIOD + 8; c++) begin
      tick(((xs.size() % 2) == 0), 1'b1);
      nchk++;
      if (pcm_valid !== hv || pcm_data !== hd || overrun !== hov) begin
        nerr++;
        $display("FAIL alternating edge %0d: got v=%0b d=%0d o=%0b, want v=%0b d=%0d o=%0b", k, pcm_valid, pcm_data, overrun, hv, hd, hov);
      end
      if (pcm_valid) smp.push_back(pcm_data);
    end
    for (int i = 2; i < smp.size(); i++) begin
      nchk++; if (smp[i] !== 0) begin nerr++; $display("FAIL alt_settled[%0d]: got %0d want 0", i, smp[i]); end
    end
  endtask

  task automatic test_lr_sel();
    int last;
    for (int sel = 0; sel < 2; sel++) begin
      lr_sel = sel[0];
      restart();
      last = 0;
      for (int c = 0; c < 4 * PERIOD + 8; c++) begin
        // data is 1 only in the cycle that ends on an mclk rising edge
        tick(((k % CLK_DIV) == CLK_DIV / 2 - 1), 1'b1);
        nchk++;
        if (pcm_valid !== hv || pcm_data !== hd || overrun !== hov) begin
          nerr++;
          $display("FAIL lr_sel%0d edge %0d: got v=%0b d=%0d o=%0b, want v=%0b d=%0d o=%0b", sel, k, pcm_valid, pcm_data, overrun, hv, hd, hov);
        end
        if (pcm_valid) last = pcm_data;
      end
      nchk++;
      if (last !== (sel == 0 ? 32767 : -32768)) begin
        nerr++; $display("FAIL lr_sel%0d_result: got %0d want %0d", sel, last, sel == 0 ? 32767 : -32768);
      end
    end
    lr_sel = 1'b0;
  endtask

  task automatic test_ready_coincident();
    restart();
    for (int c = 0; c < 4 * PERIOD + 8; c++) begin
      tick(1'($urandom), (pend_e.size() > 0 && pend_e[0] == k + 1));
      nchk++;
      if (pcm_valid !== hv || pcm_data !== hd || overrun !== hov) begin
        nerr++;
        $display("FAIL coincident edge %0d: got v=%0b d=%0d o=%0b, want v=%0b d=%0d o=%0b", k, pcm_valid, pcm_data, overrun, hv, hd, hov);
      end
    end
    nchk++; if (overrun !== 1'b0) begin nerr++; $display("FAIL coincident_overrun: got %0b want 0", overrun); end
    nchk++; if (pcm_valid !== 1'b1) begin nerr++; $display("FAIL coincident_valid: got %0b want 1", pcm_valid); end
  endtask

  task automatic test_overrun();
    pcm_ready = 1'b0;
    restart();
    for (int c = 0; c < 2 * PERIOD + 8; c++) begin
      tick(1'($urandom), 1'b0);
      nchk++;
      if (pcm_valid !== hv || pcm_data !== hd || overrun !== hov) begin
        nerr++;
        $display("FAIL overrun edge %0d: got v=%0b d=%0d o=%0b, want v=%0b d=%0d o=%0b", k, pcm_valid, pcm_data, overrun, hv, hd, hov);
      end
    end
    nchk++; if (overrun !== 1'b1) begin nerr++; $display("FAIL overrun_set: got %0b want 1", overrun); end
    enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick(1'b1, 1'b0);
      nchk++;
      if (pcm_valid !== 1'b1 || pcm_data !== hd || mclk !== 1'b0) begin
        nerr++;
        $display("FAIL disabled_hold: got v=%0b d=%0d mclk=%0b, want v=1 d=%0d mclk=0", pcm_valid, pcm_data, mclk, hd);
      end
    end
    tick(1'b1, 1'b1);
    nchk++; if (pcm_valid !== 1'b0) begin nerr++; $display("FAIL disabled_consume: got %0b want 0", pcm_valid); end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    int first;
    restart();
    for (int c = 0; c < 101; c++) tick(1'($urandom), 1'b1);
    reset = 1'b1;
    tick(1'b1, 1'b1);
    nchk++;
    if (mclk !== 1'b0 || pcm_data !== 16'sd0 || pcm_valid !== 1'b0 || overrun !== 1'b0) begin
      nerr++;
      $display("FAIL reset_mid: got mclk=%0b d=%0d v=%0b o=%0b, want all 0", mclk, pcm_data, pcm_valid, overrun);
    end
    reset = 1'b0;
    first = -1;
    for (int c = 0; c < PERIOD + 40; c++) begin
      tick(1'($urandom), 1'b1);
      nchk++;
      if (pcm_valid !== hv || pcm_data !== hd || overrun !== hov) begin
        nerr++;
        $display("FAIL after_reset edge %0d: got v=%0b d=%0d o=%0b, want v=%0b d=%0d o=%0b", k, pcm_valid, pcm_data, overrun, hv, hd, hov);
      end
      if (pcm_valid && first < 0) first = k;
    end
    // 64th strobe lands on edge CLK_DIV*63 + CLK_DIV/2, load follows 2 clk later
    nchk++;
    if (first !== CLK_DIV * (R - 1) + CLK_DIV / 2 + 2) begin
      nerr++; $display("FAIL first_valid_latency: got %0d want %0d", first, CLK_DIV * (R - 1) + CLK_DIV / 2 + 2);
    end
  endtask

  task automatic test_random();
    lr_sel = 1'($urandom);
    restart();
    for (int c = 0; c < 9 * PERIOD; c++) begin
      if (c == 3 * PERIOD + 1) lr_sel = ~lr_sel;
      tick(1'($urandom), ($urandom_range(0, 3) != 0));
      nchk++;
      if (pcm_valid !== hv || pcm_data !== hd || overrun !== hov) begin
        nerr++;
        $display("FAIL random edge %0d: got v=%0b d=%0d o=%0b, want v=%0b d=%0d o=%0b", k, pcm_valid, pcm_data, overrun, hv, hd, hov);
      end
    end
  endtask

  initial begin
    test_reset();
    test_const_one();
    test_const_zero();
    test_alternating();
    test_lr_sel();
    test_ready_coincident();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
